// File: rtl/rf_wport_sched.sv
// Register-file write-port scheduler. Arbitrates between the pipeline writeback and the long-latency unit.
// It also tracks long-latency destinations that are still pending, so decode can stall on hazards.
module rf_wport_sched #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_OUT      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_hold,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic [4:0]  chk_rd,
    output logic        hazard_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [2:0]  outstanding,
    output logic        err_proto
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [2:0]    OUT_MAX    = 3'(MAX_OUT);

    logic [31:0]   busy_q, busy_d;
    logic [2:0]    out_q, out_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          hold_q, hold_d;
    logic          err_q, err_d;

    logic lu_acc;
    logic iss_ok;
    logic dec_ok;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        lu_ready = 1'b0;
        if (wb_valid) begin
            rf_we    = (wb_rd != 5'd0);
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (lu_valid) begin
            lu_ready = 1'b1;
            rf_we    = (lu_rd != 5'd0);
            rf_waddr = lu_rd;
            rf_wdata = lu_data;
        end
    end

    assign lu_acc = lu_valid && lu_ready;
    assign iss_ok = iss_valid && (out_q != OUT_MAX);
    assign dec_ok = lu_acc && (out_q != 3'd0);

    always_comb begin
        starve_d = starve_q;
        if (lu_valid && !lu_ready) begin
            if (starve_q != STARVE_MAX)
                starve_d = starve_q + SW'(1);
        end else begin
            starve_d = '0;
        end
        hold_d = (starve_d == STARVE_MAX);
    end

    // Clear before set so a same-cycle reissue of the returning rd stays busy.
    always_comb begin
        busy_d = busy_q;
        if (lu_acc)
            busy_d[lu_rd] = 1'b0;
        if (iss_ok && iss_rd != 5'd0)
            busy_d[iss_rd] = 1'b1;
        out_d = out_q + {2'b00, iss_ok} - {2'b00, dec_ok};
    end

    always_comb begin
        err_d = err_q;
        if (iss_valid && out_q == OUT_MAX)
            err_d = 1'b1;
        if (lu_acc && out_q == 3'd0)
            err_d = 1'b1;
        if (wb_valid && hold_q)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            out_q    <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            out_q    <= out_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
        end
    end

    assign hazard_stall = (busy_q[chk_rs1] && chk_rs1 != 5'd0)
                       || (busy_q[chk_rs2] && chk_rs2 != 5'd0)
                       || (busy_q[chk_rd]  && chk_rd  != 5'd0)
                       || (out_q == OUT_MAX);
    assign wb_hold     = hold_q;
    assign outstanding = out_q;
    assign err_proto   = err_q;

endmodule

// File: tb/tb_rf_wport_sched.sv
// Directed bench for rf_wport_sched: arbitration, starvation hold, scoreboard, protocol errors, async reset.
module tb_rf_wport_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_hold;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1, chk_rs2, chk_rd;
    logic        hazard_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  outstanding;
    logic        err_proto;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wport_sched #(.STARVE_LIMIT(4), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_hold(wb_hold),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard_stall(hazard_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .outstanding(outstanding), .err_proto(err_proto)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the rising edge then commits them.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        iss_valid = 0; iss_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cyc();
        rst = 0;
        cyc();
    endtask

    initial begin
        idle();
        rst = 1;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_hold", wb_hold, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_err", err_proto, 0);
        chk("rst_luready", lu_ready, 0);
        chk("rst_hazard", hazard_stall, 0);
        @(negedge clk);
        rst = 0;
        cyc();

        // wb beats lu, lu takes the next free cycle
        wb_valid = 1; wb_rd = 5; wb_data = 32'hAAAA0001;
        lu_valid = 1; lu_rd = 6; lu_data = 32'h12345678;
        #1;
        chk("arb_wb_we", rf_we, 1);
        chk("arb_wb_addr", rf_waddr, 5);
        chk("arb_wb_data", rf_wdata, 32'hAAAA0001);
        chk("arb_wb_luready", lu_ready, 0);
        cyc();
        wb_valid = 0;
        #1;
        chk("arb_lu_addr", rf_waddr, 6);
        chk("arb_lu_data", rf_wdata, 32'h12345678);
        chk("arb_lu_luready", lu_ready, 1);
        chk("arb_lu_we", rf_we, 1);
        cyc();
        lu_valid = 0;
        #1;
        chk("underflow_err", err_proto, 1);
        chk("underflow_out", outstanding, 0);
        chk("idle_we", rf_we, 0);

        // starvation: refused for 4 cycles, hold in cycle 5
        do_reset();
        iss_valid = 1; iss_rd = 6;
        cyc();
        iss_valid = 0; iss_rd = 0;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1; wb_rd = 1; wb_data = i;
            lu_valid = 1; lu_rd = 6; lu_data = 32'hCAFE0006;
            #1;
            chk($sformatf("starve_hold_c%0d", i), wb_hold, 0);
            cyc();
        end
        wb_valid = 0;
        #1;
        chk("starve_hold_c5", wb_hold, 1);
        chk("starve_grant_c5", lu_ready, 1);
        chk("starve_addr_c5", rf_waddr, 6);
        cyc();
        lu_valid = 0;
        #1;
        chk("starve_hold_c6", wb_hold, 0);
        chk("starve_err_c6", err_proto, 0);
        chk("starve_out_c6", outstanding, 0);

        // hold violation: wb keeps presenting while held
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1; wb_rd = 2; lu_valid = 1; lu_rd = 9;
            cyc();
        end
        #1;
        chk("viol_hold", wb_hold, 1);
        chk("viol_wb_wins", rf_waddr, 2);
        chk("viol_luready", lu_ready, 0);
        cyc();
        idle();
        #1;
        chk("viol_err", err_proto, 1);

        // scoreboard, rd=7 then rd=0
        do_reset();
        iss_valid = 1; iss_rd = 7; chk_rs1 = 7;
        #1;
        chk("sb_same_cycle_invisible", hazard_stall, 0);
        cyc();
        iss_valid = 0; iss_rd = 0;
        #1;
        chk("sb_rs1_stall", hazard_stall, 1);
        chk("sb_out1", outstanding, 1);
        lu_valid = 1; lu_rd = 7; lu_data = 32'h77;
        #1;
        chk("sb_accept_still_stall", hazard_stall, 1);
        cyc();
        lu_valid = 0;
        #1;
        chk("sb_cleared", hazard_stall, 0);
        chk("sb_out0", outstanding, 0);
        chk_rs1 = 0;
        iss_valid = 1; iss_rd = 0;
        cyc();
        iss_valid = 0;
        #1;
        chk("sb_rd0_out", outstanding, 1);
        chk("sb_rd0_nostall", hazard_stall, 0);
        lu_valid = 1; lu_rd = 0; lu_data = 32'h55;
        #1;
        chk("sb_rd0_we", rf_we, 0);
        chk("sb_rd0_ready", lu_ready, 1);
        cyc();
        lu_valid = 0;
        #1;
        chk("sb_rd0_out_back", outstanding, 0);
        chk("sb_rd0_err", err_proto, 0);
        chk("sb_rd0_nostall2", hazard_stall, 0);

        // fill to MAX_OUT, then overflow
        for (int r = 1; r <= 4; r++) begin
            iss_valid = 1; iss_rd = r[4:0];
            cyc();
        end
        iss_valid = 0; iss_rd = 0;
        #1;
        chk("full_out", outstanding, 4);
        chk("full_stall", hazard_stall, 1);
        iss_valid = 1; iss_rd = 5;
        cyc();
        iss_valid = 0; iss_rd = 0;
        #1;
        chk("ovf_out", outstanding, 4);
        chk("ovf_err", err_proto, 1);
        lu_valid = 1; lu_rd = 4;
        cyc();
        lu_valid = 0;
        chk_rs2 = 2;
        #1;
        chk("rs2_stall", hazard_stall, 1);
        chk_rs2 = 0; chk_rd = 3;
        #1;
        chk("waw_stall", hazard_stall, 1);
        chk_rd = 4;
        #1;
        chk("rd4_free", hazard_stall, 0);
        chk_rs1 = 5;
        #1;
        chk("ignored_issue_not_busy", hazard_stall, 0);
        chk_rs1 = 0; chk_rd = 0;

        // same-cycle issue and accept
        do_reset();
        iss_valid = 1; iss_rd = 9;
        cyc();
        lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
        cyc();
        iss_valid = 0; lu_valid = 0; chk_rs1 = 9;
        #1;
        chk("same_rd_busy", hazard_stall, 1);
        chk("same_rd_out", outstanding, 1);
        iss_valid = 1; iss_rd = 10; lu_valid = 1; lu_rd = 9;
        cyc();
        iss_valid = 0; lu_valid = 0;
        #1;
        chk("diff_rd_out", outstanding, 1);
        chk("diff_rd9_clear", hazard_stall, 0);
        chk_rs1 = 10;
        #1;
        chk("diff_rd10_busy", hazard_stall, 1);

        // async reset mid-operation
        do_reset();
        iss_valid = 1; iss_rd = 3;
        cyc();
        iss_rd = 8;
        cyc();
        iss_valid = 0; iss_rd = 0;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1; wb_rd = 1; lu_valid = 1; lu_rd = 5;
            cyc();
        end
        idle();
        chk_rs1 = 3;
        #1;
        chk("pre_rst_hold", wb_hold, 1);
        chk("pre_rst_out", outstanding, 2);
        chk("pre_rst_stall", hazard_stall, 1);
        rst = 1;
        #1;
        chk("mid_rst_hold", wb_hold, 0);
        chk("mid_rst_out", outstanding, 0);
        chk("mid_rst_err", err_proto, 0);
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_stall", hazard_stall, 0);
        @(negedge clk);
        rst = 0;
        cyc();
        #1;
        chk("post_rst_stall", hazard_stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
